maze_map: RTL and testbench

// - Maze storage stage serving the maze-follower FSM. Holds a 64x64 wall bitmap (1=wall, 0=free), loaded from a byte stream.
// - Answers the follower's row/col reads on maze_in.
// - Records cells the follower marks with maze_we in a separate visited bitmap and counts them.
// - Freezes and flags completion when the follower raises done.

---
 rtl/maze_map.sv | 169 ++++++++++++++++
 tb/tb_maze_map.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_map.sv
// maze_map: 64x64 wall bitmap loaded from a byte stream, plus a visited
// bitmap and distinct-visit counter for the maze-follower FSM.
// Optional feature macro: MAZE_MAP_READBACK_EN adds a visited-map readback
// port (rb_en/rb_row/rb_col/rb_visited) that is active only in SOLVED.
module maze_map #(
  parameter int unsigned MAZE_WIDTH = 6,
  parameter int unsigned BYTE_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [BYTE_W-1:0]       load_data,
  output logic                    load_ready,
  input  logic [MAZE_WIDTH-1:0]   row,
  input  logic [MAZE_WIDTH-1:0]   col,
  input  logic                    maze_oe,
  input  logic                    maze_we,
  input  logic                    done,
  output logic                    maze_in,
  output logic                    map_ready,
  output logic [2*MAZE_WIDTH:0]   visit_cnt,
  output logic                    solved
`ifdef MAZE_MAP_READBACK_EN
  ,
  input  logic                    rb_en,
  input  logic [MAZE_WIDTH-1:0]   rb_row,
  input  logic [MAZE_WIDTH-1:0]   rb_col,
  output logic                    rb_visited
`endif
);

  localparam int unsigned SIDE    = 1 << MAZE_WIDTH;
  localparam int unsigned LANES   = SIDE / BYTE_W;
  localparam int unsigned LANE_W  = $clog2(LANES);
  localparam int unsigned ADDR_W  = MAZE_WIDTH + LANE_W;
  localparam int unsigned BEATS   = SIDE * LANES;
  localparam int unsigned CNT_W   = 2 * MAZE_WIDTH + 1;
  localparam int unsigned CNT_MAX = SIDE * SIDE;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    LOAD   = 2'd1,
    READY  = 2'd2,
    SOLVED = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [MAZE_WIDTH-1:0]  clr_row;
  logic [ADDR_W-1:0]      load_addr;
  logic                   fire;
  logic                   last_beat;
  logic                   vis_bit;
  logic                   mark;
  logic                   load_ready_d;
  logic                   map_ready_d;
  logic                   solved_d;

  logic [SIDE-1:0]        wall_mem    [SIDE];
  logic [SIDE-1:0]        visited_mem [SIDE];

  assign fire      = load_valid & load_ready;
  assign last_beat = fire && (load_addr == ADDR_W'(BEATS - 1));
  assign vis_bit   = visited_mem[row][col];
  assign mark      = (state == READY) && maze_we && !vis_bit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Next-state logic: clear sweep, load stream, serve, then freeze
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_row == MAZE_WIDTH'(SIDE - 1)) state_next = LOAD;
      LOAD:    if (last_beat) state_next = READY;
      READY:   if (done) state_next = SOLVED;
      SOLVED:  state_next = SOLVED;
      default: state_next = CLEAR;
    endcase
  end

  // Output decode from the upcoming state so status flags are registered
  always_comb begin
    load_ready_d = 1'b0;
    map_ready_d  = 1'b0;
    solved_d     = 1'b0;
    case (state_next)
      LOAD:    load_ready_d = 1'b1;
      READY:   map_ready_d  = 1'b1;
      SOLVED:  solved_d     = 1'b1;
      default: ;
    endcase
  end

  // Registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_ready <= 1'b0;
      map_ready  <= 1'b0;
      solved     <= 1'b0;
    end else begin
      load_ready <= load_ready_d;
      map_ready  <= map_ready_d;
      solved     <= solved_d;
    end
  end

  // Clear-sweep row pointer and load byte address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_row   <= '0;
      load_addr <= '0;
    end else begin
      if (state == CLEAR) clr_row <= clr_row + MAZE_WIDTH'(1);
      if (fire)           load_addr <= load_addr + ADDR_W'(1);
    end
  end

  // Read port: wall bit in READY, forced wall elsewhere, hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maze_in <= 1'b1;
    end else if (maze_oe) begin
      maze_in <= (state == READY) ? wall_mem[row][col] : 1'b1;
    end
  end

  // Distinct-visit counter, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      visit_cnt <= '0;
    end else if (mark && (visit_cnt != CNT_W'(CNT_MAX))) begin
      visit_cnt <= visit_cnt + CNT_W'(1);
    end
  end

  // Wall bitmap written one byte lane per accepted beat
  always_ff @(posedge clk) begin
    if (fire) begin
      wall_mem[load_addr[ADDR_W-1:LANE_W]][int'(load_addr[LANE_W-1:0]) * BYTE_W +: BYTE_W] <= load_data;
    end
  end

  // Visited bitmap: row sweep during CLEAR, single-cell marks during READY
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      visited_mem[clr_row] <= '0;
    end else if ((state == READY) && maze_we) begin
      visited_mem[row][col] <= 1'b1;
    end
  end

`ifdef MAZE_MAP_READBACK_EN
  // Visited readback, live only once the map is frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_visited <= 1'b0;
    end else if (state != SOLVED) begin
      rb_visited <= 1'b0;
    end else if (rb_en) begin
      rb_visited <= visited_mem[rb_row][rb_col];
    end
  end
`endif

endmodule

// File: tb/tb_maze_map.sv
// tb_maze_map: self-checking bench for maze_map against a cell-level model.
module tb_maze_map;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic [5:0]  row;
  logic [5:0]  col;
  logic        maze_oe;
  logic        maze_we;
  logic        done;
  logic        maze_in;
  logic        map_ready;
  logic [12:0] visit_cnt;
  logic        solved;
`ifdef MAZE_MAP_READBACK_EN
  logic        rb_en;
  logic [5:0]  rb_row;
  logic [5:0]  rb_col;
  logic        rb_visited;
`endif

  maze_map dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .row        (row),
    .col        (col),
    .maze_oe    (maze_oe),
    .maze_we    (maze_we),
    .done       (done),
    .maze_in    (maze_in),
    .map_ready  (map_ready),
    .visit_cnt  (visit_cnt),
    .solved     (solved)
`ifdef MAZE_MAP_READBACK_EN
    ,
    .rb_en      (rb_en),
    .rb_row     (rb_row),
    .rb_col     (rb_col),
    .rb_visited (rb_visited)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        n_cmp;
  int        n_bad;
  bit [63:0] ref_wall [64];
  bit [63:0] ref_vis  [64];
  int        ref_cnt;
  int        ref_phase;   // 0 not ready, 1 ready, 2 solved
  logic      exp_mi;

  task automatic idle();
    load_valid = 1'b0;
    load_data  = '0;
    row        = '0;
    col        = '0;
    maze_oe    = 1'b0;
    maze_we    = 1'b0;
    done       = 1'b0;
`ifdef MAZE_MAP_READBACK_EN
    rb_en  = 1'b0;
    rb_row = '0;
    rb_col = '0;
`endif
  endtask

  task automatic model_reset();
    foreach (ref_vis[i]) ref_vis[i] = '0;
    ref_cnt   = 0;
    ref_phase = 0;
    exp_mi    = 1'b1;
  endtask

  task automatic randomize_map();
    foreach (ref_wall[i]) ref_wall[i] = {$urandom, $urandom};
  endtask

  // One follower cycle; the model applies the cell-level rules afterwards
  task automatic step(input int r, input int c, input bit oe, input bit we, input bit dn);
    @(negedge clk);
    row = 6'(r); col = 6'(c); maze_oe = oe; maze_we = we; done = dn;
    @(posedge clk); #1;
    if (oe) exp_mi = (ref_phase == 1) ? logic'(ref_wall[r][c]) : 1'b1;
    if (we && ref_phase == 1 && !ref_vis[r][c]) begin
      ref_vis[r][c] = 1'b1;
      if (ref_cnt < 4096) ref_cnt++;
    end
    if (dn && ref_phase == 1) ref_phase = 2;
    maze_oe = 1'b0; maze_we = 1'b0; done = 1'b0;
  endtask

  task automatic wait_clear(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!load_ready && cyc < 300);
  endtask

  task automatic load_map(input bit toggle, input int n_beats, output int cyc);
    int   beats;
    logic rdy;
    beats = 0;
    cyc   = 0;
    while (beats < n_beats && cyc < 3000) begin
      @(negedge clk);
      load_valid = toggle ? logic'(cyc % 2 == 0) : 1'b1;
      load_data  = ref_wall[beats / 8][(beats % 8) * 8 +: 8];
      rdy        = load_ready;
      @(posedge clk);
      if (rdy && load_valid) beats++;
      cyc++;
    end
    #1;
    if (n_beats == 512) begin
      n_cmp++;
      if (map_ready !== 1'b1 || load_ready !== 1'b0 || beats != 512) begin
        n_bad++;
        $display("FAIL load_done: map_ready=%b load_ready=%b beats=%0d, want 1 0 512", map_ready, load_ready, beats);
      end
      ref_phase = 1;
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    @(negedge clk);
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    n_cmp++;
    if ({load_ready, map_ready, solved} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: load_ready/map_ready/solved=%b, want 000", {load_ready, map_ready, solved});
    end
    n_cmp++;
    if (maze_in !== 1'b1 || visit_cnt !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_data: maze_in=%b visit_cnt=%0d, want 1 0", maze_in, visit_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_clear(cyc);
    n_cmp++;
    if (cyc != 64) begin
      n_bad++;
      $display("FAIL clear_len: load_ready after %0d cycles, want 64", cyc);
    end
  endtask

  task automatic test_spec_load();
    int cyc;
    foreach (ref_wall[i]) ref_wall[i] = '1;
    ref_wall[5][7:0] = 8'hFE;
    load_map(1'b0, 512, cyc);
    n_cmp++;
    if (cyc != 512) begin
      n_bad++;
      $display("FAIL load_cycles: took %0d cycles, want 512", cyc);
    end
    step(5, 1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (maze_in !== exp_mi) begin
      n_bad++;
      $display("FAIL read_5_1: maze_in=%b, want %b", maze_in, exp_mi);
    end
    step(5, 0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (maze_in !== exp_mi) begin
      n_bad++;
      $display("FAIL read_5_0: maze_in=%b, want %b", maze_in, exp_mi);
    end
    step(5, 1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (maze_in !== exp_mi) begin
      n_bad++;
      $display("FAIL read_hold: maze_in=%b, want %b", maze_in, exp_mi);
    end
  endtask

  task automatic test_toggle_load();
    int cyc;
    @(negedge clk);
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    wait_clear(cyc);
    randomize_map();
    load_map(1'b1, 512, cyc);
    n_cmp++;
    if (cyc != 1023) begin
      n_bad++;
      $display("FAIL toggle_load_cycles: took %0d cycles, want 1023", cyc);
    end
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(63), $urandom_range(63), ($urandom % 4) != 0, 1'b0, 1'b0);
      n_cmp++;
      if (maze_in !== exp_mi) begin
        n_bad++;
        $display("FAIL rand_read[%0d]: maze_in=%b, want %b", i, maze_in, exp_mi);
      end
    end
  endtask

  task automatic test_visit();
    step(3, 4, 1'b0, 1'b1, 1'b0);
    step(3, 4, 1'b0, 1'b1, 1'b0);
    step(3, 5, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (visit_cnt !== 13'(ref_cnt) || ref_cnt != 2) begin
      n_bad++;
      $display("FAIL visit_two: visit_cnt=%0d, want 2", visit_cnt);
    end
    step(3, 4, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (maze_in !== exp_mi || visit_cnt !== 13'd2) begin
      n_bad++;
      $display("FAIL oe_we_same: maze_in=%b cnt=%0d, want %b 2", maze_in, visit_cnt, exp_mi);
    end
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(7), $urandom_range(7), $urandom_range(1), $urandom_range(1), 1'b0);
      n_cmp++;
      if (maze_in !== exp_mi || visit_cnt !== 13'(ref_cnt)) begin
        n_bad++;
        $display("FAIL rand_visit[%0d]: maze_in=%b cnt=%0d, want %b %0d", i, maze_in, visit_cnt, exp_mi, ref_cnt);
      end
    end
`ifdef MAZE_MAP_READBACK_EN
    @(negedge clk);
    rb_en = 1'b1; rb_row = 6'd3; rb_col = 6'd4;
    @(posedge clk); #1;
    rb_en = 1'b0;
    n_cmp++;
    if (rb_visited !== 1'b0) begin
      n_bad++;
      $display("FAIL rb_not_solved: rb_visited=%b, want 0", rb_visited);
    end
`endif
  endtask

  task automatic test_done();
    int fr;
    int fc;
    step(60, 60, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (solved !== 1'b1 || map_ready !== 1'b0 || visit_cnt !== 13'(ref_cnt)) begin
      n_bad++;
      $display("FAIL done_edge: solved=%b map_ready=%b cnt=%0d, want 1 0 %0d", solved, map_ready, visit_cnt, ref_cnt);
    end
    fr = 10; fc = 0;
    for (int r = 10; r < 60; r++)
      for (int c = 0; c < 64; c++)
        if (ref_wall[r][c] == 1'b0) begin fr = r; fc = c; end
    step(fr, fc, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (maze_in !== exp_mi || visit_cnt !== 13'(ref_cnt) || solved !== 1'b1) begin
      n_bad++;
      $display("FAIL solved_frozen: maze_in=%b cnt=%0d solved=%b, want %b %0d 1", maze_in, visit_cnt, solved, exp_mi, ref_cnt);
    end
`ifdef MAZE_MAP_READBACK_EN
    for (int i = 0; i < 20; i++) begin
      int r;
      int c;
      r = (i == 0) ? 60 : int'($urandom_range(7));
      c = (i == 0) ? 60 : int'($urandom_range(7));
      @(negedge clk);
      rb_en = 1'b1; rb_row = 6'(r); rb_col = 6'(c);
      @(posedge clk); #1;
      rb_en = 1'b0;
      n_cmp++;
      if (rb_visited !== logic'(ref_vis[r][c])) begin
        n_bad++;
        $display("FAIL rb_read[%0d]: rb_visited=%b, want %b", i, rb_visited, ref_vis[r][c]);
      end
    end
`endif
  endtask

  task automatic test_rst_midload();
    int cyc;
    int fr;
    int fc;
    @(negedge clk);
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    wait_clear(cyc);
    randomize_map();
    load_map(1'b0, 200, cyc);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({load_ready, map_ready, solved, maze_in} !== 4'b0001 || visit_cnt !== 13'd0) begin
      n_bad++;
      $display("FAIL midload_rst: lr/mr/sv/mi=%b cnt=%0d, want 0001 0", {load_ready, map_ready, solved, maze_in}, visit_cnt);
    end
    fr = 0; fc = 0;
    for (int r = 0; r < 25; r++)
      for (int c = 0; c < 64; c++)
        if (ref_wall[r][c] == 1'b0) begin fr = r; fc = c; end
    @(negedge clk);
    rst = 1'b0;
    row = 6'(fr); col = 6'(fc); maze_oe = 1'b1; maze_we = 1'b1;
    @(posedge clk); #1;
    maze_oe = 1'b0; maze_we = 1'b0;
    n_cmp++;
    if (maze_in !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_read: maze_in=%b, want 1", maze_in);
    end
    wait_clear(cyc);
    n_cmp++;
    if (cyc + 1 != 64) begin
      n_bad++;
      $display("FAIL reclear_len: load_ready after %0d cycles, want 64", cyc + 1);
    end
    load_map(1'b0, 512, cyc);
    n_cmp++;
    if (visit_cnt !== 13'd0) begin
      n_bad++;
      $display("FAIL reload_cnt: visit_cnt=%0d, want 0", visit_cnt);
    end
    step(fr, fc, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (maze_in !== exp_mi) begin
      n_bad++;
      $display("FAIL reload_read: maze_in=%b, want %b", maze_in, exp_mi);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        step(r, c, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (visit_cnt !== 13'(ref_cnt) || ref_cnt != 4096) begin
      n_bad++;
      $display("FAIL all_marked: visit_cnt=%0d, want 4096", visit_cnt);
    end
    step(0, 0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (visit_cnt !== 13'd4096) begin
      n_bad++;
      $display("FAIL remark_full: visit_cnt=%0d, want 4096", visit_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    wait_clear(cyc);
    load_map(1'b0, 512, cyc);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    step(63, 63, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (visit_cnt !== 13'(ref_cnt) || ref_cnt != 2) begin
      n_bad++;
      $display("FAIL revisit_after_rst: visit_cnt=%0d, want 2", visit_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_spec_load();
    test_toggle_load();
    test_visit();
    test_done();
    test_rst_midload();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
